// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM encoding and default width.
package timer_pkg;

  localparam int TIMER_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_e;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause/resume, terminal-count pulse and optional
// auto-reload for periodic operation.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             tick,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt,
  output logic             zero,
  output logic             busy,
  output logic             expired
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expired_q, expired_d;

  logic cnt_nz, reload_nz, terminal;

  assign cnt_nz    = (cnt_q != '0);
  assign reload_nz = (reload_q != '0);
  // cnt==1 is the last tick; 0 is never decremented.
  assign terminal  = (cnt_q == WIDTH'(1));

  // State, count, reload and expired registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
    end
  end

  // Next state and datapath; load overrides everything, then stop, start, tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    if (load) begin
      cnt_d    = load_val;
      reload_d = load_val;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE, PAUSED: begin
          if (start && cnt_nz) state_d = RUN;
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSED;
          end else if (tick) begin
            if (terminal) begin
              expired_d = 1'b1;
              if (auto_reload && reload_nz) begin
                cnt_d = reload_q;
              end else begin
                cnt_d   = '0;
                state_d = DONE;
              end
            end else if (cnt_nz) begin
              cnt_d = cnt_q - WIDTH'(1);
            end
          end
        end
        DONE: begin
          if (start && reload_nz) begin
            cnt_d   = reload_q;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs, all derived from registers.
  always_comb begin
    cnt     = cnt_q;
    zero    = ~cnt_nz;
    busy    = (state_q == RUN);
    expired = expired_q;
  end

endmodule
